// File: rtl/alu_issue_stage.sv
// Command FIFO and result slot around the combinational alu: buffers commands,
// drives the head entry onto the alu ports and captures tagged results.
module alu_issue_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_carry,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_out,
  output logic                     res_carry,
  output logic [SEL_W-1:0]         res_sel,
  output logic [15:0]              res_tag,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  logic [SEL_W-1:0] mem_sel [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [15:0]      issue_cnt;
  logic             push, pop, fifo_nonempty;

  assign fifo_nonempty = (count != '0);
  // in_ready depends only on the registered count, so a full FIFO refuses
  // a push even when the slot pops in the same cycle.
  assign in_ready   = (count != CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_count = count;

  assign alu_a   = fifo_nonempty ? mem_a[rd_ptr]   : '0;
  assign alu_b   = fifo_nonempty ? mem_b[rd_ptr]   : '0;
  assign alu_sel = fifo_nonempty ? mem_sel[rd_ptr] : '0;

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    res_valid  = (state == S_FULL);
    case (state)
      S_EMPTY: begin
        if (fifo_nonempty) begin
          pop        = 1'b1;
          next_state = S_FULL;
        end
      end
      S_FULL: begin
        if (res_ready) begin
          if (fifo_nonempty) pop = 1'b1;
          else               next_state = S_EMPTY;
        end
      end
      default: next_state = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_sel[wr_ptr] <= in_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_out   <= '0;
      res_carry <= 1'b0;
      res_sel   <= '0;
      res_tag   <= '0;
      issue_cnt <= '0;
    end else if (pop) begin
      res_out   <= alu_out;
      res_carry <= alu_carry;
      res_sel   <= alu_sel;
      res_tag   <= issue_cnt;
      issue_cnt <= issue_cnt + 16'd1;
    end
  end

endmodule
